// File: rtl/axis_video_out.sv
// AXI4-Stream video sink: FIFO-buffered pixels are aligned to a free-running raster
// generator by a lock FSM that also flags underflow and misplaced tuser/tlast.
module axis_video_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        s_axis_vid_aclk,
  input  logic        s_axis_vid_aresetn,
  input  logic [31:0] s_axis_vid_tdata,
  input  logic        s_axis_vid_tvalid,
  output logic        s_axis_vid_tready,
  input  logic        s_axis_vid_tuser,
  input  logic        s_axis_vid_tlast,
  output logic [23:0] vid_data,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic        locked,
  output logic        underflow,
  output logic        sync_err,
  input  logic        err_clr
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_LOCKED} state_t;

  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [23:0] data;
  } entry_t;

  state_t        state, state_nxt;
  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          full, empty, push, pop;
  logic          active, hs, vs, frame_end, viol;
  logic          set_uf, set_se, pix_ok;
  logic          unused_pad;

  assign unused_pad = ^s_axis_vid_tdata[31:24];

  // ---------------- FIFO ----------------
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_axis_vid_tready = s_axis_vid_aresetn && !full;
  assign push  = s_axis_vid_tvalid && s_axis_vid_tready;
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; only the pointers define what is valid.
  always_ff @(posedge s_axis_vid_aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_axis_vid_tuser, s_axis_vid_tlast, s_axis_vid_tdata[23:0]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
    if (!s_axis_vid_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // ---------------- raster timing ----------------
  always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
    if (!s_axis_vid_aresetn) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  assign active    = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign hs        = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs        = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign viol      = (head.tuser != ((hcnt == '0) && (vcnt == '0)))
                  || (head.tlast != (hcnt == HW'(H_ACTIVE - 1)));

  // ---------------- lock FSM ----------------
  always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
    if (!s_axis_vid_aresetn) state <= ST_SEARCH;
    else                     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: if (!empty && head.tuser) state_nxt = ST_WAIT;
      ST_WAIT:   if (frame_end) state_nxt = ST_LOCKED;
      ST_LOCKED: if (active && (empty || viol)) state_nxt = ST_SEARCH;
      default:   state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    pop    = 1'b0;
    set_uf = 1'b0;
    set_se = 1'b0;
    pix_ok = 1'b0;
    case (state)
      ST_SEARCH: pop = !empty && !head.tuser;
      ST_LOCKED: begin
        if (active) begin
          if (empty) begin
            set_uf = 1'b1;
          end else begin
            pop    = 1'b1;
            set_se = viol;
            pix_ok = !viol;
          end
        end
      end
      default: ;
    endcase
  end

  assign locked = (state == ST_LOCKED);

  // ---------------- registered video outputs and sticky flags ----------------
  always_ff @(posedge s_axis_vid_aclk or negedge s_axis_vid_aresetn) begin
    if (!s_axis_vid_aresetn) begin
      vid_data  <= '0;
      vid_de    <= 1'b0;
      vid_hsync <= ~HS_POL;
      vid_vsync <= ~VS_POL;
      underflow <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      vid_data  <= pix_ok ? head.data : 24'd0;
      vid_de    <= active;
      vid_hsync <= hs ? HS_POL : ~HS_POL;
      vid_vsync <= vs ? VS_POL : ~VS_POL;
      // A new error outranks a clear arriving in the same cycle.
      if (set_uf)       underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
      if (set_se)       sync_err  <= 1'b1;
      else if (err_clr) sync_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_video_out.sv
// Directed bench for axis_video_out on an 8x6 raster (4x3 active) with a 4-entry FIFO.
module tb_axis_video_out;

  localparam int HT = 8;    // H_TOTAL
  localparam int FT = 48;   // clocks per frame

  typedef struct {
    logic        tuser;
    logic        tlast;
    logic [23:0] data;
  } beat_t;

  typedef struct {
    int          pos;
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] data;
  } vec_t;

  logic        clk, rst_n, err_clr;
  logic [31:0] tdata;
  logic        tvalid, tready, tuser, tlast;
  logic [23:0] vid_data;
  logic        vid_hsync, vid_vsync, vid_de, locked, underflow, sync_err;

  int    checks = 0;
  int    errors = 0;
  int    cyc;
  int    src_idx;
  int    stall_lo = -1;
  int    stall_hi = -1;
  logic  fire;
  beat_t q[$];
  vec_t  vecs[14];

  axis_video_out #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FIFO_DEPTH(4)
  ) dut (
    .s_axis_vid_aclk   (clk),
    .s_axis_vid_aresetn(rst_n),
    .s_axis_vid_tdata  (tdata),
    .s_axis_vid_tvalid (tvalid),
    .s_axis_vid_tready (tready),
    .s_axis_vid_tuser  (tuser),
    .s_axis_vid_tlast  (tlast),
    .vid_data          (vid_data),
    .vid_hsync         (vid_hsync),
    .vid_vsync         (vid_vsync),
    .vid_de            (vid_de),
    .locked            (locked),
    .underflow         (underflow),
    .sync_err          (sync_err),
    .err_clr           (err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Interval index: 0 right after reset release, +1 per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Stream source: presents q[src_idx] and advances on each accepted beat.
  initial begin
    tvalid  = 1'b0;
    tdata   = '0;
    tuser   = 1'b0;
    tlast   = 1'b0;
    src_idx = 0;
    forever begin
      @(negedge clk);
      fire = tvalid && tready;
      @(posedge clk);
      #1;
      if (!rst_n)    src_idx = 0;
      else if (fire) src_idx++;
      tvalid = (src_idx < q.size()) && !(cyc >= stall_lo && cyc <= stall_hi);
      if (src_idx < q.size()) begin
        tdata = {8'h5A, q[src_idx].data};
        tuser = q[src_idx].tuser;
        tlast = q[src_idx].tlast;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (interval %0d)", name, act, exp, cyc);
    end
  endtask

  // Park at the middle of interval n; outputs then reflect raster position n-1.
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    err_clr  = 1'b0;
    stall_lo = -1;
    stall_hi = -1;
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add_garbage(input int n);
    for (int i = 0; i < n; i++) q.push_back('{1'b0, 1'b0, 24'hAA0000 + 24'(i)});
  endtask

  // Pixels 1..12; bad=1 moves the first line's tlast from pixel 4 to pixel 3.
  task automatic add_frame(input bit bad);
    for (int i = 0; i < 12; i++) begin
      logic tl;
      tl = (i % 4 == 3);
      if (bad && i == 2) tl = 1'b1;
      if (bad && i == 3) tl = 1'b0;
      q.push_back('{(i == 0), tl, 24'(i + 1)});
    end
  endtask

  task automatic check_frame(input int base, input string tag);
    for (int r = 0; r < FT; r++) begin
      int          h, v;
      logic        act;
      logic [23:0] exp;
      h   = r % HT;
      v   = r / HT;
      act = (h < 4) && (v < 3);
      exp = act ? 24'(v * 4 + h + 1) : 24'd0;
      wait_cyc(base + r + 1);
      check({tag, "_data"}, vid_data, exp);
      check({tag, "_de"}, vid_de, act);
    end
  endtask

  task automatic check_zero(input int lo, input int hi, input string tag);
    for (int n = lo; n <= hi; n++) begin
      wait_cyc(n);
      check(tag, vid_data, 24'd0);
    end
  endtask

  task automatic pulse_clr(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0,  1'b1, 1'b1, 1'b1, 24'd0};
    vecs[1]  = '{3,  1'b1, 1'b1, 1'b1, 24'd0};
    vecs[2]  = '{4,  1'b1, 1'b1, 1'b0, 24'd0};
    vecs[3]  = '{5,  1'b0, 1'b1, 1'b0, 24'd0};
    vecs[4]  = '{6,  1'b0, 1'b1, 1'b0, 24'd0};
    vecs[5]  = '{7,  1'b1, 1'b1, 1'b0, 24'd0};
    vecs[6]  = '{19, 1'b1, 1'b1, 1'b1, 24'd0};
    vecs[7]  = '{24, 1'b1, 1'b1, 1'b0, 24'd0};
    vecs[8]  = '{32, 1'b1, 1'b0, 1'b0, 24'd0};
    vecs[9]  = '{37, 1'b0, 1'b0, 1'b0, 24'd0};
    vecs[10] = '{39, 1'b1, 1'b0, 1'b0, 24'd0};
    vecs[11] = '{40, 1'b1, 1'b1, 1'b0, 24'd0};
    vecs[12] = '{47, 1'b1, 1'b1, 1'b0, 24'd0};
    vecs[13] = '{48, 1'b1, 1'b1, 1'b1, 24'd0};

    // 1: reset values, then three clean frames
    do_reset();
    check("rst_data", vid_data, 24'd0);
    check("rst_de", vid_de, 1'b0);
    check("rst_hsync", vid_hsync, 1'b1);
    check("rst_vsync", vid_vsync, 1'b1);
    check("rst_locked", locked, 1'b0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_tready", tready, 1'b0);
    for (int f = 0; f < 3; f++) add_frame(1'b0);
    release_reset();
    wait_cyc(47);
    check("s1_locked_47", locked, 1'b0);
    wait_cyc(48);
    check("s1_locked_48", locked, 1'b1);
    check_frame(48, "s1_f1");
    check_frame(96, "s1_f2");
    check_frame(144, "s1_f3");
    check("s1_underflow", underflow, 1'b0);
    check("s1_sync_err", sync_err, 1'b0);
    wait_cyc(194);
    check("s1_dry_underflow", underflow, 1'b1);
    check("s1_dry_locked", locked, 1'b0);

    // 2: sync timing with no stream
    do_reset();
    release_reset();
    foreach (vecs[i]) begin
      wait_cyc(vecs[i].pos + 1);
      check($sformatf("s2_hsync_p%0d", vecs[i].pos), vid_hsync, vecs[i].hs);
      check($sformatf("s2_vsync_p%0d", vecs[i].pos), vid_vsync, vecs[i].vs);
      check($sformatf("s2_de_p%0d", vecs[i].pos), vid_de, vecs[i].de);
      check($sformatf("s2_data_p%0d", vecs[i].pos), vid_data, vecs[i].data);
    end
    check("s2_locked", locked, 1'b0);

    // 3: garbage ahead of the first SOF is discarded
    do_reset();
    add_garbage(5);
    add_frame(1'b0);
    release_reset();
    check_zero(1, 47, "s3_pre_lock_data");
    wait_cyc(48);
    check("s3_locked_48", locked, 1'b1);
    check_frame(48, "s3_f1");
    check("s3_sync_err", sync_err, 1'b0);

    // 4: early tlast on the first line, relock on the next SOF
    do_reset();
    add_frame(1'b1);
    add_frame(1'b0);
    release_reset();
    wait_cyc(49);
    check("s4_px1", vid_data, 24'd1);
    wait_cyc(50);
    check("s4_px2", vid_data, 24'd2);
    check("s4_sync_err_before", sync_err, 1'b0);
    wait_cyc(51);
    check("s4_sync_err", sync_err, 1'b1);
    check("s4_locked_lost", locked, 1'b0);
    check_zero(51, 96, "s4_blank_data");
    check("s4_relocked", locked, 1'b1);
    check_frame(96, "s4_f2");
    check("s4_sync_err_sticky", sync_err, 1'b1);
    check("s4_underflow", underflow, 1'b0);

    // 5: source stall drains the FIFO mid-frame
    do_reset();
    add_frame(1'b0);
    add_frame(1'b0);
    stall_lo = 57;
    stall_hi = 64;
    release_reset();
    wait_cyc(57);
    check("s5_px5", vid_data, 24'd5);
    wait_cyc(60);
    check("s5_px8", vid_data, 24'd8);
    pulse_clr(64);
    wait_cyc(65);
    check("s5_underflow_wins_clr", underflow, 1'b1);
    check("s5_uf_data", vid_data, 24'd0);
    check("s5_uf_de", vid_de, 1'b1);
    check("s5_uf_locked", locked, 1'b0);
    wait_cyc(78);
    check("s5_underflow_sticky", underflow, 1'b1);
    pulse_clr(80);
    wait_cyc(82);
    check("s5_underflow_cleared", underflow, 1'b0);
    wait_cyc(96);
    check("s5_relocked", locked, 1'b1);
    check_frame(96, "s5_f2");
    check("s5_underflow_after", underflow, 1'b0);

    // 6: back-pressure while waiting, then reset mid-line
    do_reset();
    add_frame(1'b0);
    add_frame(1'b0);
    release_reset();
    wait_cyc(20);
    check("s6_tready_full", tready, 1'b0);
    check("s6_tvalid_held", tvalid, 1'b1);
    check("s6_beats_accepted", 32'(src_idx), 32'd4);
    check("s6_locked_wait", locked, 1'b0);
    check_frame(48, "s6_f1");
    wait_cyc(98);
    check("s6_pre_rst_data", vid_data, 24'd2);
    check("s6_pre_rst_de", vid_de, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_data", vid_data, 24'd0);
    check("s6_rst_de", vid_de, 1'b0);
    check("s6_rst_hsync", vid_hsync, 1'b1);
    check("s6_rst_vsync", vid_vsync, 1'b1);
    check("s6_rst_locked", locked, 1'b0);
    check("s6_rst_tready", tready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
